// File: rtl/cpu_pkg.sv
// Shared core widths and the reorder-buffer entry layout; the rename stage imports the same package.
package cpu_pkg;

    localparam int ROB_DEPTH = 16;
    localparam int PTR_W     = $clog2(ROB_DEPTH);
    localparam int PHYS_W    = 6;
    localparam int ARCH_W    = 5;

    typedef struct packed {
        logic              valid;
        logic              done;
        logic [ARCH_W-1:0] rd;
        logic [PHYS_W-1:0] phys_rd;
        logic [PHYS_W-1:0] old_phys_rd;
    } rob_entry_t;

endpackage

// File: rtl/rob_ptr.sv
// Wrap-bit pointer: W index bits plus one lap bit, so equal indices can be told apart as full or empty.
module rob_ptr #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         inc,
    output logic [W:0]   ptr
);

    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            ptr <= '0;
        else if (inc)
            ptr <= ptr + (W+1)'(1);
    end

endmodule

// File: rtl/reorder_retire.sv
// In-order retirement buffer: allocates at tail, marks out-of-order completions, retires from head
// and returns the previous physical mapping of each retired instruction to rename.
module reorder_retire
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              alloc_valid,
    input  logic [ARCH_W-1:0] alloc_rd,
    input  logic [PHYS_W-1:0] alloc_phys_rd,
    input  logic [PHYS_W-1:0] alloc_old_phys_rd,
    output logic [PTR_W-1:0]  alloc_tag,
    output logic              rob_full,
    output logic              rob_empty,
    input  logic              wb_valid,
    input  logic [PTR_W-1:0]  wb_tag,
    output logic              retire_valid,
    output logic [PHYS_W-1:0] retire_phys_reg,
    output logic [ARCH_W-1:0] retire_rd,
    output logic              overflow_err
);

    logic [PTR_W:0]   head;
    logic [PTR_W:0]   tail;
    logic [PTR_W-1:0] head_idx;
    logic [PTR_W-1:0] tail_idx;
    logic             do_alloc;
    logic             do_retire;
    logic             wb_hit;
    rob_entry_t       rob [ROB_DEPTH];

    assign head_idx  = head[PTR_W-1:0];
    assign tail_idx  = tail[PTR_W-1:0];
    assign rob_empty = (head == tail);
    assign rob_full  = (head_idx == tail_idx) && (head[PTR_W] != tail[PTR_W]);
    assign alloc_tag = tail_idx;

    // Full is judged on current pointers: a same-edge retire does not make room for this alloc.
    assign do_alloc  = alloc_valid && !rob_full;
    assign do_retire = !rob_empty && rob[head_idx].valid && rob[head_idx].done;
    assign wb_hit    = wb_valid && rob[wb_tag].valid;

    rob_ptr #(.W(PTR_W)) u_head_ptr (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (do_retire),
        .ptr     (head)
    );

    rob_ptr #(.W(PTR_W)) u_tail_ptr (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (do_alloc),
        .ptr     (tail)
    );

    // NOTE: the whole entry array is reset, since valid/done must be clear the instant reset lands.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < ROB_DEPTH; i++)
                rob[i] <= '0;
            retire_valid    <= 1'b0;
            retire_phys_reg <= '0;
            retire_rd       <= '0;
            overflow_err    <= 1'b0;
        end else begin
            retire_valid <= do_retire;
            overflow_err <= alloc_valid && rob_full;
            if (wb_hit)
                rob[wb_tag].done <= 1'b1;
            if (do_retire) begin
                rob[head_idx].valid <= 1'b0;
                rob[head_idx].done  <= 1'b0;
                retire_phys_reg     <= rob[head_idx].old_phys_rd;
                retire_rd           <= rob[head_idx].rd;
            end
            // Head and tail never share an index here: that needs full (no alloc) or empty (no retire).
            if (do_alloc)
                rob[tail_idx] <= '{valid: 1'b1, done: 1'b0, rd: alloc_rd,
                                   phys_rd: alloc_phys_rd, old_phys_rd: alloc_old_phys_rd};
        end
    end

endmodule
